// File: rtl/panel_input_ctrl.sv
// rtl/panel_input_ctrl.sv - front-panel button debounce plus power/speed/action state machine.
// Optional AUTO_OFF_EN builds an inactivity timer that returns the panel to OFF after IDLE_CYCLES.
module panel_input_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned IDLE_CYCLES     = 1500000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_onoff,
  input  logic btn_spd_up,
  input  logic btn_spd_dn,
  input  logic btn_act,
  output logic onoff,
  output logic A_spd,
  output logic B_spd,
  output logic A_act,
  output logic B_act,
  output logic C_act
);

  localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {S_OFF, S_ON} state_t;

  // Button index order: 0 onoff, 1 speed up, 2 speed down, 3 action.
  logic [3:0]    w_btn;
  logic [3:0]    r_sync1;
  logic [3:0]    r_sync2;
  logic [3:0]    r_deb;
  logic [3:0]    r_evt;
  logic [DW-1:0] r_cnt [4];

  state_t        r_state;
  state_t        w_state_nxt;
  logic [1:0]    r_spd;
  logic [1:0]    w_spd_nxt;
  logic [2:0]    r_act;
  logic [2:0]    w_act_nxt;
  logic          w_idle_expire;

  assign w_btn = {btn_act, btn_spd_dn, btn_spd_up, btn_onoff};

  // The counter only runs while the synchronized level disagrees with the accepted one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
      r_deb   <= '1;
      r_evt   <= '0;
      for (int i = 0; i < 4; i++) r_cnt[i] <= '0;
    end else begin
      r_sync1 <= w_btn;
      r_sync2 <= r_sync1;
      for (int i = 0; i < 4; i++) begin
        r_evt[i] <= 1'b0;
        if (r_sync2[i] == r_deb[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == DEB_LAST) begin
          r_cnt[i] <= '0;
          r_deb[i] <= r_sync2[i];
          r_evt[i] <= ~r_sync2[i];
        end else begin
          r_cnt[i] <= r_cnt[i] + DW'(1);
        end
      end
    end
  end

`ifdef AUTO_OFF_EN
  localparam int unsigned IW = $clog2(IDLE_CYCLES + 1);
  logic [IW-1:0] r_idle;

  // A press landing on the expiry cycle counts as activity and wins over the timeout.
  assign w_idle_expire = (r_state == S_ON) && (r_idle == IW'(IDLE_CYCLES)) && (r_evt == 4'b0000);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idle <= '0;
    end else if ((r_state != S_ON) || (r_evt != 4'b0000) || w_idle_expire) begin
      r_idle <= '0;
    end else begin
      r_idle <= r_idle + IW'(1);
    end
  end
`else
  assign w_idle_expire = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_OFF;
      r_spd   <= '0;
      r_act   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_spd   <= w_spd_nxt;
      r_act   <= w_act_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_spd_nxt   = r_spd;
    w_act_nxt   = r_act;
    case (r_state)
      S_OFF: begin
        w_spd_nxt = '0;
        w_act_nxt = '0;
        if (r_evt[0]) w_state_nxt = S_ON;
      end
      S_ON: begin
        if (r_evt[0] || w_idle_expire) begin
          w_state_nxt = S_OFF;
          w_spd_nxt   = '0;
          w_act_nxt   = '0;
        end else begin
          if (r_evt[1] && !r_evt[2] && (r_spd != 2'd3)) begin
            w_spd_nxt = r_spd + 2'd1;
          end else if (r_evt[2] && !r_evt[1] && (r_spd != 2'd0)) begin
            w_spd_nxt = r_spd - 2'd1;
          end
          if (r_evt[3]) begin
            w_act_nxt = (r_act >= 3'd4) ? 3'd0 : (r_act + 3'd1);
          end
        end
      end
      default: begin
        w_state_nxt = S_OFF;
        w_spd_nxt   = '0;
        w_act_nxt   = '0;
      end
    endcase
  end

  assign onoff = (r_state == S_ON);
  assign A_spd = r_spd[0];
  assign B_spd = r_spd[1];
  assign A_act = r_act[0];
  assign B_act = r_act[1];
  assign C_act = r_act[2];

endmodule

// File: tb/tb_panel_input_ctrl.sv
// tb/tb_panel_input_ctrl.sv - directed and randomized checks of panel_input_ctrl against a sample-window model.
module tb_panel_input_ctrl;

  localparam int DEB  = 4;
  localparam int IDLE = 50;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] btn = 4'b1111;
  logic       onoff, A_spd, B_spd, A_act, B_act, C_act;
  logic [5:0] obs_vec;
  bit         chk_en = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  panel_input_ctrl #(
    .DEBOUNCE_CYCLES(DEB),
    .IDLE_CYCLES    (IDLE)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_onoff (btn[0]),
    .btn_spd_up(btn[1]),
    .btn_spd_dn(btn[2]),
    .btn_act   (btn[3]),
    .onoff     (onoff),
    .A_spd     (A_spd),
    .B_spd     (B_spd),
    .A_act     (A_act),
    .B_act     (B_act),
    .C_act     (C_act)
  );

  always #5 clk = ~clk;

  assign obs_vec = {onoff, B_spd, A_spd, C_act, B_act, A_act};

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: a level is accepted once the last DEB synchronized samples (raw delayed two
  // clocks) all disagree with it; a press takes effect on the following clock.
  logic [7:0] m_hist [4];
  logic [3:0] m_deb, m_pend, m_new;
  bit         m_on;
  int         m_spd, m_act, m_idle;

  task automatic model_rst();
    for (int b = 0; b < 4; b++) m_hist[b] = 8'hFF;
    m_deb  = 4'b1111;
    m_pend = 4'b0000;
    m_on   = 1'b0;
    m_spd  = 0;
    m_act  = 0;
    m_idle = 0;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_rst();
    end else begin
      m_new = 4'b0000;
      for (int b = 0; b < 4; b++) begin
        m_hist[b] = {m_hist[b][6:0], btn[b]};
        if (m_hist[b][DEB+1:2] == {DEB{~m_deb[b]}}) begin
          m_deb[b] = ~m_deb[b];
          m_new[b] = ~m_deb[b];
        end
      end
      if (m_pend[0]) begin
        m_on  = !m_on;
        m_spd = 0;
        m_act = 0;
      end else if (m_on) begin
`ifdef AUTO_OFF_EN
        if (m_pend == 4'b0000 && m_idle == IDLE) begin
          m_on  = 1'b0;
          m_spd = 0;
          m_act = 0;
        end
`endif
        if (m_pend[1] && !m_pend[2]) m_spd = (m_spd < 3) ? m_spd + 1 : 3;
        else if (m_pend[2] && !m_pend[1]) m_spd = (m_spd > 0) ? m_spd - 1 : 0;
        if (m_pend[3]) m_act = (m_act + 1) % 5;
      end
`ifdef AUTO_OFF_EN
      if (!m_on || m_pend != 4'b0000) m_idle = 0;
      else m_idle++;
`endif
      m_pend = m_new;
    end
  end

  always @(negedge clk) begin
    if (chk_en) chk("model_outs", obs_vec, {m_on, m_spd[1:0], m_act[2:0]});
  end

  task automatic press(input logic [3:0] mask, input int len);
    btn = ~mask;
    repeat (len) @(negedge clk);
    btn = 4'b1111;
    repeat (8) @(negedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int exp_up[4]  = '{1, 2, 3, 3};
    int exp_dn[4]  = '{2, 1, 0, 0};
    int exp_act[6] = '{1, 2, 3, 4, 0, 1};

    model_rst();
    #1 rst_n = 1'b0;
    chk_en = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_outs", obs_vec, 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Power on latency: outputs move on the 7th edge after the raw falling edge.
    btn[0] = 1'b0;
    repeat (6) @(negedge clk);
    chk("pwr_lat6", onoff, 0);
    @(negedge clk);
    chk("pwr_lat7", onoff, 1);
    chk("pwr_spd", {B_spd, A_spd}, 0);
    chk("pwr_act", {C_act, B_act, A_act}, 0);
    repeat (3) @(negedge clk);
    btn[0] = 1'b1;
    repeat (8) @(negedge clk);
    press(4'b0001, 10);
    chk("pwr_off", onoff, 0);
    press(4'b0001, 10);
    chk("pwr_on2", onoff, 1);

    // Bounce: short lows never reach the debounce window.
    repeat (5) begin
      btn[1] = 1'b0;
      repeat (3) @(negedge clk);
      btn[1] = 1'b1;
      @(negedge clk);
    end
    repeat (8) @(negedge clk);
    chk("bounce_spd", {B_spd, A_spd}, 0);
    press(4'b0010, 10);
    chk("bounce_final", {B_spd, A_spd}, 1);

    press(4'b0001, 10);
    press(4'b0001, 10);
    for (int i = 0; i < 4; i++) begin
      press(4'b0010, 10);
      chk("sat_up", {B_spd, A_spd}, exp_up[i]);
    end
    for (int i = 0; i < 4; i++) begin
      press(4'b0100, 10);
      chk("sat_dn", {B_spd, A_spd}, exp_dn[i]);
    end

    for (int i = 0; i < 6; i++) begin
      press(4'b1000, 10);
      chk("act_wrap", {C_act, B_act, A_act}, exp_act[i]);
    end
    press(4'b0001, 10);
    chk("act_off_clear", {C_act, B_act, A_act}, 0);
    press(4'b1000, 10);
    press(4'b1000, 10);
    chk("act_in_off", {C_act, B_act, A_act}, 0);
    chk("act_in_off_pwr", onoff, 0);

    // Priority and simultaneous events.
    press(4'b0001, 10);
    press(4'b0010, 10);
    press(4'b0010, 10);
    repeat (3) press(4'b1000, 10);
    chk("prio_setup", obs_vec, 6'b1_10_011);
    press(4'b0011, 10);
    chk("prio_onoff", obs_vec, 0);
    press(4'b0001, 10);
    press(4'b0010, 10);
    press(4'b0010, 10);
    press(4'b0110, 10);
    chk("updn_same", {B_spd, A_spd}, 2);
    press(4'b1010, 10);
    chk("act_and_up", obs_vec, 6'b1_11_001);

    // Asynchronous reset in the middle of an onoff debounce.
    btn[0] = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk("rst_async", obs_vec, 0);
    btn[0] = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("rst_no_event", obs_vec, 0);
    press(4'b0001, 10);
    chk("rst_then_on", obs_vec, 6'b1_00_000);

`ifdef AUTO_OFF_EN
    repeat (60) @(negedge clk);
    chk("auto_off", onoff, 0);
`else
    repeat (200) @(negedge clk);
    chk("no_auto_off", onoff, 1);
`endif

    // Randomized mixes of presses, glitches and overlaps, checked continuously against the model.
    for (int i = 0; i < 150; i++) begin
      logic [3:0] mask;
      int len, gap;
      mask = 4'($urandom_range(1, 15));
      if (mask[0] && $urandom_range(0, 3) != 0) mask[0] = 1'b0;
      len = $urandom_range(1, 12);
      gap = $urandom_range(0, 10);
      btn = ~mask;
      repeat (len) @(negedge clk);
      btn = 4'b1111;
      repeat (gap) @(negedge clk);
    end
    repeat (12) @(negedge clk);
    chk_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
